// File: rtl/mig_sram_pkg.sv
// Shared types and constants for the MigU SRAM arbiter.
package mig_sram_pkg;

  // Which requester owns the read data returning from the SRAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } rsp_owner_t;

  // Width of the fetch starvation counter.
  localparam int STARVE_CNT_W = 4;

  // Ports carry word addresses: the two byte-offset bits are dropped.
  function automatic int word_addr_w(input int addr_width);
    return addr_width - 2;
  endfunction

endpackage

// File: rtl/mig_sram_starve_guard.sv
// Counts consecutive cycles in which a pending fetch loses to the LSU and
// forces a fetch win once the count reaches STARVE_LIMIT.
module mig_sram_starve_guard
  import mig_sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_valid,
  input  logic ls_granted,
  input  logic if_granted,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // The force flag is the counter sitting at the limit; fetch then wins and
  // the counter clears through the if_granted path below.
  assign force_if = (cnt_q == LIMIT);

  // Next count: clear when fetch is idle or served, bump when LSU beats it.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_valid || if_granted) begin
      cnt_d = '0;
    end else if (ls_granted) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mig_sram_arbiter.sv
// Single-port SRAM arbiter between the MigU fetch port and the LSU port.
// One access per cycle, LSU priority with a fetch starvation guard, read
// data routed back to the winner exactly one cycle after the grant.
module mig_sram_arbiter
  import mig_sram_pkg::*;
#(
  parameter int  ADDR_WIDTH   = 16,
  parameter int  DATA_WIDTH   = 32,
  parameter int  STARVE_LIMIT = 4,
  localparam int WAW          = word_addr_w(ADDR_WIDTH),
  localparam int BEW          = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [WAW-1:0]        if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [WAW-1:0]        ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [BEW-1:0]        ls_req_be,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [BEW-1:0]        sram_be,
  output logic [WAW-1:0]        sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  logic       force_if;
  logic       if_grant;
  logic       ls_grant;
  rsp_owner_t rsp_owner_q;
  rsp_owner_t rsp_owner_d;

  // Grant decision: LSU first unless the guard forces fetch; nothing in reset.
  always_comb begin
    if_grant = 1'b0;
    ls_grant = 1'b0;
    if (!rst) begin
      if (if_req_valid && (force_if || !ls_req_valid)) begin
        if_grant = 1'b1;
      end else if (ls_req_valid) begin
        ls_grant = 1'b1;
      end
    end
  end

  // A grant is the accept: requesters hold valid, so ready == grant.
  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  // SRAM drive muxed from the winner; everything zero when idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (if_grant) begin
      sram_en   = 1'b1;
      sram_be   = '1;
      sram_addr = if_req_addr;
    end else if (ls_grant) begin
      sram_en    = 1'b1;
      sram_we    = ls_req_we;
      sram_be    = ls_req_be;
      sram_addr  = ls_req_addr;
      sram_wdata = ls_req_wdata;
    end
  end

  // Record who owns next cycle's read data; writes produce no response.
  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (if_grant) begin
      rsp_owner_d = OWN_IF;
    end else if (ls_grant && !ls_req_we) begin
      rsp_owner_d = OWN_LS;
    end
  end

  // Owner register; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner_q <= OWN_NONE;
    end else begin
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign if_rsp_valid = (rsp_owner_q == OWN_IF);
  assign ls_rsp_valid = (rsp_owner_q == OWN_LS);
  assign if_rsp_data  = if_rsp_valid ? sram_rdata : '0;
  assign ls_rsp_data  = ls_rsp_valid ? sram_rdata : '0;

  mig_sram_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .clk         (clk),
    .rst         (rst),
    .if_req_valid(if_req_valid),
    .ls_granted  (ls_grant),
    .if_granted  (if_grant),
    .force_if    (force_if)
  );

endmodule

// File: tb/tb_mig_sram_arbiter.sv
// Scoreboard bench for mig_sram_arbiter: a reference model predicts grants,
// SRAM drive and read responses; a monitor pops and checks responses.
module tb_mig_sram_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int LIMIT = 4;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [BW-1:0] ls_req_be;
  logic [DW-1:0] ls_req_wdata, ls_rsp_data;
  logic          sram_en, sram_we;
  logic [BW-1:0] sram_be;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  always #5 clk = ~clk;

  mig_sram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_be(ls_req_be), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM the arbiter talks to (synchronous read, byte-enabled write).
  logic [DW-1:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:WORDS-1];
  int denied_run = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    bit            is_if;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: check combinational outputs against the model,
  // queue the expected response, update the model.
  task automatic step(output bit d_if_rdy, input bit mid_reset);
    bit g_if, g_ls;
    exp_t e;
    #1;
    g_if = !rst && if_req_valid && (denied_run >= LIMIT || !ls_req_valid);
    g_ls = !rst && ls_req_valid && !g_if;
    d_if_rdy = if_req_ready;
    chk("if_req_ready", if_req_ready, g_if);
    chk("ls_req_ready", ls_req_ready, g_ls);
    chk("sram_en", sram_en, g_if || g_ls);
    chk("sram_we", sram_we, g_ls && ls_req_we);
    chk("sram_be", sram_be, g_if ? 4'hF : (g_ls ? ls_req_be : 4'h0));
    chk("sram_addr", sram_addr, g_if ? if_req_addr : (g_ls ? ls_req_addr : '0));
    chk("sram_wdata", sram_wdata, g_ls ? ls_req_wdata : '0);
    if (g_if) begin
      e.due = cyc + 1; e.is_if = 1'b1; e.data = ref_mem[if_req_addr];
      exp_q.push_back(e);
    end else if (g_ls && !ls_req_we) begin
      e.due = cyc + 1; e.is_if = 1'b0; e.data = ref_mem[ls_req_addr];
      exp_q.push_back(e);
    end else if (g_ls) begin
      for (int b = 0; b < BW; b++)
        if (ls_req_be[b]) ref_mem[ls_req_addr][8*b +: 8] = ls_req_wdata[8*b +: 8];
    end
    if (rst || !if_req_valid || g_if) denied_run = 0;
    else denied_run = denied_run + 1;
    if (mid_reset) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      denied_run = 0;
      #1;
      chk("rst_drops_rsp", if_rsp_valid, 1'b0);
    end
    @(negedge clk);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      tests++; fails++;
      $display("FAIL rsp_missing: got no response expected data %0h (cycle %0d)", exp_q[0].data, cyc);
      void'(exp_q.pop_front());
    end
    if (if_rsp_valid || ls_rsp_valid) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: got if_v=%0b ls_v=%0b expected none (cycle %0d)",
                 if_rsp_valid, ls_rsp_valid, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("if_rsp_valid", if_rsp_valid, e.is_if);
        chk("ls_rsp_valid", ls_rsp_valid, !e.is_if);
        if (e.is_if) chk("if_rsp_data", if_rsp_data, e.data);
        else         chk("ls_rsp_data", ls_rsp_data, e.data);
      end
    end else begin
      chk("idle_rsp_data", {if_rsp_data, ls_rsp_data}, 64'h0);
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    bit d_if;
    bit prev_if, prev_ls;
    logic [AW-1:0] ones;
    ones = '1;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      ref_mem[i] = mem[i];
    end
    mem[16'h0010] = 32'h0000_0013; ref_mem[16'h0010] = 32'h0000_0013;
    mem[16'h0030] = 32'h0;         ref_mem[16'h0030] = 32'h0;

    rst = 1'b1;
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_we = 0; ls_req_be = '0; ls_req_wdata = '0;
    @(negedge clk);
    step(d_if, 0);
    // Requests during reset must not be granted.
    if_req_valid = 1; ls_req_valid = 1;
    step(d_if, 0);
    rst = 1'b0; if_req_valid = 0; ls_req_valid = 0;
    step(d_if, 0);

    // Fetch-only read of 0x0010.
    if_req_valid = 1; if_req_addr = 14'h0010;
    step(d_if, 0);
    if_req_valid = 0;
    step(d_if, 0);

    // Contention: LSU read of 0x0020 wins, fetch served next.
    if_req_valid = 1; if_req_addr = 14'h0011;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 14'h0020;
    step(d_if, 0);
    ls_req_valid = 0;
    step(d_if, 0);
    if_req_valid = 0;
    step(d_if, 0);

    // Starvation: both held valid; fetch must win every fifth cycle.
    if_req_valid = 1; if_req_addr = 14'h0040;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 14'h0020;
    for (int k = 0; k < 15; k++) begin
      step(d_if, 0);
      chk("starve_pattern", d_if, (k % 5) == 4);
      if (d_if) if_req_addr = if_req_addr + 1'b1;
      else      ls_req_addr = ls_req_addr + 1'b1;
    end
    if_req_valid = 0; ls_req_valid = 0;
    step(d_if, 0);

    // Partial write then read-back of 0x0030.
    ls_req_valid = 1; ls_req_we = 1; ls_req_be = 4'b0011;
    ls_req_addr = 14'h0030; ls_req_wdata = 32'hDEAD_BEEF;
    step(d_if, 0);
    ls_req_we = 0; ls_req_be = '0; ls_req_wdata = '0;
    step(d_if, 0);
    ls_req_valid = 0;
    step(d_if, 0);
    chk("partial_write_model", ref_mem[14'h0030], 32'h0000_BEEF);

    // Back-to-back fetch reads 0, 1, 2.
    if_req_valid = 1;
    for (int a = 0; a < 3; a++) begin
      if_req_addr = AW'(a);
      step(d_if, 0);
    end
    // All-ones address through both ports, including a write.
    if_req_addr = ones;
    step(d_if, 0);
    if_req_valid = 0;
    ls_req_valid = 1; ls_req_we = 1; ls_req_be = 4'hF; ls_req_addr = ones; ls_req_wdata = 32'hCAFE_F00D;
    step(d_if, 0);
    ls_req_we = 0;
    step(d_if, 0);
    ls_req_valid = 0;
    step(d_if, 0);

    // Reset in the cycle after a fetch accept.
    if_req_valid = 1; if_req_addr = 14'h0005;
    step(d_if, 1);
    step(d_if, 0);
    step(d_if, 0);
    rst = 1'b0;
    step(d_if, 0);
    if_req_valid = 0;
    step(d_if, 0);

    // Randomized traffic; payloads held until the model says accepted.
    prev_if = 1; prev_ls = 1;
    for (int n = 0; n < 400; n++) begin
      bit g_ls_m;
      if (!if_req_valid || prev_if) begin
        if_req_valid = ($urandom % 4) != 0;
        if_req_addr  = rnd_addr();
      end
      if (!ls_req_valid || prev_ls) begin
        ls_req_valid = ($urandom % 3) != 0;
        ls_req_we    = $urandom % 2;
        ls_req_be    = BW'($urandom);
        ls_req_addr  = rnd_addr();
        ls_req_wdata = $urandom;
      end
      g_ls_m = ls_req_valid && !(if_req_valid && (denied_run >= LIMIT));
      step(d_if, 0);
      prev_if = d_if;
      prev_ls = g_ls_m;
    end

    if_req_valid = 0; ls_req_valid = 0;
    step(d_if, 0);
    step(d_if, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
